// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- instruction-decode (ID) stage of the five-stage MIPS pipeline.
//
// Decodes the IF/ID instruction into WB/MEM/EX control fields, reads the
// 32x32 register file (which lives here and takes its write port from
// MEM/WB), sign-extends the immediate and registers everything into the
// ID/EX pipeline register.
//
// Build option:
//   DECODE_RF_BYPASS_EN  when defined, a register-file read that targets the
//                        register being written back in the same cycle
//                        returns the write-back data (write-through). When
//                        undefined, such a read returns the old stored value
//                        and the new value is seen one decode later.
// ---------------------------------------------------------------------------
module decode (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_write_reg_location,
   input  logic [31:0] mem_wb_write_data,
   input  logic [31:0] if_id_instr,
   input  logic [31:0] if_id_npc,
   output logic [1:0]  id_ex_wb,
   output logic [2:0]  id_ex_mem,
   output logic [3:0]  if_ex_execute,
   output logic [31:0] id_ex_npc,
   output logic [31:0] id_ex_readdat1,
   output logic [31:0] id_ex_readdat2,
   output logic [31:0] id_ex_sign_ext,
   output logic [4:0]  id_ex_instr_bits_2016,
   output logic [4:0]  id_ex_instr_bits_1511
);

   // Opcodes recognised by this stage; anything else decodes as a bubble.
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;

   // Instruction fields.
   logic [5:0]  opcode_s;
   logic [4:0]  rs_s;
   logic [4:0]  rt_s;
   logic [4:0]  rd_s;
   logic [15:0] imm_s;

   // Decoded control fields.
   logic [1:0]  ctrl_wb_s;
   logic [2:0]  ctrl_mem_s;
   logic [3:0]  ctrl_ex_s;

   // Register file storage and read results. Entry 0 is held at zero and is
   // never written after reset, but reads of address 0 are forced to zero
   // anyway so the invariant does not depend on the storage contents.
   logic [31:0] rf_r [0:31];
   logic [31:0] read_data1_s;
   logic [31:0] read_data2_s;
   logic [31:0] sign_ext_s;
   logic        wb_write_en_s;

   // Replicate bit 15 of a 16-bit immediate into the upper half-word.
   function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
      sign_extend16 = {{16{imm[15]}}, imm};
   endfunction

   // One register-file read port: zero for r0, optionally the in-flight
   // write-back value, otherwise the stored value.
   function automatic logic [31:0] rf_port(
      input logic [4:0]  addr,
      input logic [31:0] stored,
      input logic        wr_en,
      input logic [4:0]  wr_addr,
      input logic [31:0] wr_data
   );
      logic [31:0] result;
      if (addr == 5'd0) begin
         result = 32'd0;
      end
`ifdef DECODE_RF_BYPASS_EN
      else if (wr_en && (wr_addr == addr)) begin
         result = wr_data;
      end
`endif
      else begin
         result = stored;
      end
`ifndef DECODE_RF_BYPASS_EN
      // Without the bypass the write-port arguments do not affect the read.
      if (wr_en && (wr_addr == 5'd0) && (wr_data == 32'd0)) begin
         result = result;
      end
      else begin
         result = result;
      end
`endif
      return result;
   endfunction

   // Split the instruction into its fields.
   always_comb begin
      opcode_s = if_id_instr[31:26];
      rs_s     = if_id_instr[25:21];
      rt_s     = if_id_instr[20:16];
      rd_s     = if_id_instr[15:11];
      imm_s    = if_id_instr[15:0];
   end

   // Control decode on the opcode; unknown opcodes become a bubble.
   always_comb begin
      ctrl_wb_s  = 2'b00;
      ctrl_mem_s = 3'b000;
      ctrl_ex_s  = 4'b0000;
      case (opcode_s)
         OP_RTYPE: begin
            ctrl_wb_s  = 2'b10;
            ctrl_mem_s = 3'b000;
            ctrl_ex_s  = 4'b1100;
         end
         OP_LW: begin
            ctrl_wb_s  = 2'b11;
            ctrl_mem_s = 3'b010;
            ctrl_ex_s  = 4'b0001;
         end
         OP_SW: begin
            ctrl_wb_s  = 2'b00;
            ctrl_mem_s = 3'b001;
            ctrl_ex_s  = 4'b0001;
         end
         OP_BEQ: begin
            ctrl_wb_s  = 2'b00;
            ctrl_mem_s = 3'b100;
            ctrl_ex_s  = 4'b0010;
         end
         default: begin
            ctrl_wb_s  = 2'b00;
            ctrl_mem_s = 3'b000;
            ctrl_ex_s  = 4'b0000;
         end
      endcase
   end

   // Write-back is accepted only for non-zero destinations.
   always_comb begin
      if (wb_reg_write && (wb_write_reg_location != 5'd0)) begin
         wb_write_en_s = 1'b1;
      end
      else begin
         wb_write_en_s = 1'b0;
      end
   end

   // Two combinational read ports addressed by rs and rt.
   always_comb begin
      read_data1_s = rf_port(rs_s, rf_r[rs_s], wb_reg_write,
                             wb_write_reg_location, mem_wb_write_data);
      read_data2_s = rf_port(rt_s, rf_r[rt_s], wb_reg_write,
                             wb_write_reg_location, mem_wb_write_data);
   end

   // Immediate sign extension.
   always_comb begin
      sign_ext_s = sign_extend16(imm_s);
   end

   // Register file: reset loads register i with i; reset beats write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf_r[i] <= 32'(i);
         end
      end
      else if (wb_write_en_s) begin
         rf_r[wb_write_reg_location] <= mem_wb_write_data;
      end
   end

   // ID/EX pipeline register: cleared on reset, otherwise captures every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_wb              <= 2'b00;
         id_ex_mem             <= 3'b000;
         if_ex_execute         <= 4'b0000;
         id_ex_npc             <= 32'd0;
         id_ex_readdat1        <= 32'd0;
         id_ex_readdat2        <= 32'd0;
         id_ex_sign_ext        <= 32'd0;
         id_ex_instr_bits_2016 <= 5'd0;
         id_ex_instr_bits_1511 <= 5'd0;
      end
      else begin
         id_ex_wb              <= ctrl_wb_s;
         id_ex_mem             <= ctrl_mem_s;
         if_ex_execute         <= ctrl_ex_s;
         id_ex_npc             <= if_id_npc;
         id_ex_readdat1        <= read_data1_s;
         id_ex_readdat2        <= read_data2_s;
         id_ex_sign_ext        <= sign_ext_s;
         id_ex_instr_bits_2016 <= rt_s;
         id_ex_instr_bits_1511 <= rd_s;
      end
   end

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode -- self-checking bench for the decode stage.
// A behavioural model (register array + opcode table) predicts the ID/EX
// register contents; a compare loop checks them every cycle on the falling
// edge, and directed steps pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_decode;

   logic        clk;
   logic        rst;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg_location;
   logic [31:0] mem_wb_write_data;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_npc;
   logic [1:0]  id_ex_wb;
   logic [2:0]  id_ex_mem;
   logic [3:0]  if_ex_execute;
   logic [31:0] id_ex_npc;
   logic [31:0] id_ex_readdat1;
   logic [31:0] id_ex_readdat2;
   logic [31:0] id_ex_sign_ext;
   logic [4:0]  id_ex_instr_bits_2016;
   logic [4:0]  id_ex_instr_bits_1511;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [8:0]  ctrl;
      logic [31:0] npc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] sext;
      logic [4:0]  b2016;
      logic [4:0]  b1511;
   } exp_t;

   exp_t        pend_exp;
   exp_t        cur_exp;
   logic        model_valid = 1'b0;
   logic        pend_valid  = 1'b0;
   logic [31:0] mrf [32];

   decode dut (
      .clk                   (clk),
      .rst                   (rst),
      .wb_reg_write          (wb_reg_write),
      .wb_write_reg_location (wb_write_reg_location),
      .mem_wb_write_data     (mem_wb_write_data),
      .if_id_instr           (if_id_instr),
      .if_id_npc             (if_id_npc),
      .id_ex_wb              (id_ex_wb),
      .id_ex_mem             (id_ex_mem),
      .if_ex_execute         (if_ex_execute),
      .id_ex_npc             (id_ex_npc),
      .id_ex_readdat1        (id_ex_readdat1),
      .id_ex_readdat2        (id_ex_readdat2),
      .id_ex_sign_ext        (id_ex_sign_ext),
      .id_ex_instr_bits_2016 (id_ex_instr_bits_2016),
      .id_ex_instr_bits_1511 (id_ex_instr_bits_1511)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control table: {RegWrite,MemtoReg, Branch,MemRead,MemWrite, RegDst,ALUOp,ALUSrc}
   function automatic logic [8:0] model_ctrl(input int op);
      if (op == 0)  return 9'b10_000_1100;
      if (op == 35) return 9'b11_010_0001;
      if (op == 43) return 9'b00_001_0001;
      if (op == 4)  return 9'b00_100_0010;
      return 9'b0;
   endfunction

   function automatic logic [31:0] model_read(input int addr, input logic we,
                                              input int loc, input logic [31:0] data);
      if (addr == 0) return 32'd0;
`ifdef DECODE_RF_BYPASS_EN
      if (we && loc == addr) return data;
`endif
      return mrf[addr];
   endfunction

   function automatic logic [31:0] model_sext(input int imm);
      int v;
      v = (imm >= 32768) ? imm - 65536 : imm;
      return 32'(v);
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, predict the ID/EX register, then clock it.
   task automatic step(input logic r, input logic [31:0] instr, input logic [31:0] npc,
                       input logic we, input logic [4:0] loc, input logic [31:0] data);
      int op, rs, rt, rd, imm;
      rst = r; if_id_instr = instr; if_id_npc = npc;
      wb_reg_write = we; wb_write_reg_location = loc; mem_wb_write_data = data;
      op  = int'(instr) >>> 26 & 63;
      op  = (instr >> 26) & 63;
      rs  = (instr >> 21) & 31;
      rt  = (instr >> 16) & 31;
      rd  = (instr >> 11) & 31;
      imm = instr & 32'hFFFF;
      if (r) begin
         pend_exp = '0;
         pend_valid = 1'b1;
      end
      else begin
         pend_exp.ctrl  = model_ctrl(op);
         pend_exp.npc   = npc;
         pend_exp.rd1   = model_read(rs, we, int'(loc), data);
         pend_exp.rd2   = model_read(rt, we, int'(loc), data);
         pend_exp.sext  = model_sext(imm);
         pend_exp.b2016 = 5'(rt);
         pend_exp.b1511 = 5'(rd);
      end
      @(posedge clk);
      cur_exp = pend_exp;
      model_valid = pend_valid;
      if (r) begin
         for (int i = 0; i < 32; i++) mrf[i] = 32'(i);
      end
      else if (we && loc != 5'd0) begin
         mrf[loc] = data;
      end
      #1;
   endtask

   initial begin
      logic [31:0] rnd;
      logic [31:0] instr;
      logic [5:0]  op;
      logic [4:0]  loc;

      rst = 1'b1; wb_reg_write = 1'b0; wb_write_reg_location = 5'd0;
      mem_wb_write_data = 32'd0; if_id_instr = 32'd0; if_id_npc = 32'd0;

      // Compare loop: every falling edge once the model is meaningful.
      fork
         forever begin
            @(negedge clk);
            if (model_valid) begin
               check("cyc_ctrl", {23'd0, id_ex_wb, id_ex_mem, if_ex_execute}, {23'd0, cur_exp.ctrl});
               check("cyc_npc",  id_ex_npc,      cur_exp.npc);
               check("cyc_rd1",  id_ex_readdat1, cur_exp.rd1);
               check("cyc_rd2",  id_ex_readdat2, cur_exp.rd2);
               check("cyc_sext", id_ex_sign_ext, cur_exp.sext);
               check("cyc_bits", {22'd0, id_ex_instr_bits_2016, id_ex_instr_bits_1511},
                     {22'd0, cur_exp.b2016, cur_exp.b1511});
            end
         end
      join_none

      // Reset, with a write-back that must be ignored.
      step(1'b1, 32'h00A41020, 32'd7, 1'b1, 5'd3, 32'hDEAD);
      step(1'b1, 32'h00A41020, 32'd7, 1'b0, 5'd0, 32'd0);
      check("rst_ctrl", {23'd0, id_ex_wb, id_ex_mem, if_ex_execute}, 32'd0);
      check("rst_npc", id_ex_npc, 32'd0);
      check("rst_rd1", id_ex_readdat1, 32'd0);
      check("rst_sext", id_ex_sign_ext, 32'd0);

      step(1'b0, 32'h00220820, 32'd0, 1'b0, 5'd0, 32'd0);
      check("init_rd1", id_ex_readdat1, 32'd1);
      check("init_rd2", id_ex_readdat2, 32'd2);

      step(1'b0, 32'h00A41020, 32'd1, 1'b0, 5'd0, 32'd0);
      check("r_ctrl", {23'd0, id_ex_wb, id_ex_mem, if_ex_execute}, 32'b10_000_1100);
      check("r_rd1", id_ex_readdat1, 32'd5);
      check("r_rd2", id_ex_readdat2, 32'd4);
      check("r_sext", id_ex_sign_ext, 32'h00001020);
      check("r_2016", {27'd0, id_ex_instr_bits_2016}, 32'd4);
      check("r_1511", {27'd0, id_ex_instr_bits_1511}, 32'd2);
      check("r_npc", id_ex_npc, 32'd1);

      step(1'b0, 32'h10000008, 32'd2, 1'b0, 5'd0, 32'd0);
      check("beq_ctrl", {23'd0, id_ex_wb, id_ex_mem, if_ex_execute}, 32'b00_100_0010);
      check("beq_rd1", id_ex_readdat1, 32'd0);
      check("beq_sext", id_ex_sign_ext, 32'd8);

      step(1'b0, 32'h8C820002, 32'd3, 1'b0, 5'd0, 32'd0);
      check("lw_ctrl", {23'd0, id_ex_wb, id_ex_mem, if_ex_execute}, 32'b11_010_0001);
      check("lw_rd1", id_ex_readdat1, 32'd4);
      check("lw_sext", id_ex_sign_ext, 32'd2);
      check("lw_2016", {27'd0, id_ex_instr_bits_2016}, 32'd2);

      step(1'b0, 32'hAC820002, 32'd4, 1'b0, 5'd0, 32'd0);
      check("sw_ctrl", {23'd0, id_ex_wb, id_ex_mem, if_ex_execute}, 32'b00_001_0001);

      // Same-cycle write-back and read of r2.
      step(1'b0, 32'h00421020, 32'd5, 1'b1, 5'd2, 32'h64);
`ifdef DECODE_RF_BYPASS_EN
      check("haz_rd1", id_ex_readdat1, 32'h64);
      check("haz_rd2", id_ex_readdat2, 32'h64);
`else
      check("haz_rd1", id_ex_readdat1, 32'd2);
      check("haz_rd2", id_ex_readdat2, 32'd2);
`endif
      step(1'b0, 32'h00421020, 32'd6, 1'b0, 5'd0, 32'd0);
      check("haz_next", id_ex_readdat1, 32'h64);

      // r0 ignores writes, also in the same cycle.
      step(1'b0, 32'h00000000, 32'd7, 1'b1, 5'd0, 32'hFFFF);
      check("r0_same", id_ex_readdat1, 32'd0);
      step(1'b0, 32'h00000000, 32'd8, 1'b0, 5'd0, 32'd0);
      check("r0_after", id_ex_readdat2, 32'd0);

      step(1'b0, 32'h8C82FFFC, 32'd9, 1'b0, 5'd0, 32'd0);
      check("neg_sext", id_ex_sign_ext, 32'hFFFFFFFC);

      step(1'b0, 32'h08000000, 32'd10, 1'b0, 5'd0, 32'd0);
      check("bubble_ctrl", {23'd0, id_ex_wb, id_ex_mem, if_ex_execute}, 32'd0);

      // Randomised traffic, with occasional mid-stream reset.
      for (int n = 0; n < 400; n++) begin
         rnd = $urandom();
         case ($urandom_range(0, 4))
            0: op = 6'd0;
            1: op = 6'd35;
            2: op = 6'd43;
            3: op = 6'd4;
            default: op = 6'($urandom_range(0, 63));
         endcase
         instr = {op, rnd[25:0]};
         loc = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) loc = instr[25:21];
         if ($urandom_range(0, 3) == 0) loc = instr[20:16];
         step(($urandom_range(0, 63) == 0), instr, $urandom(),
              1'($urandom_range(0, 1)), loc, $urandom());
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
